// File: rtl/vx_reduce_packetizer.sv
// Splits a captured full-warp reduction request into per-lane-group packets,
// emitting only groups with active threads, lowest packet id first.
module vx_reduce_packetizer #(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int OP_BITS     = 4,
    parameter int META_W      = 64,
    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
    localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]   in_data,
    input  logic [OP_BITS-1:0]            in_op,
    input  logic [META_W-1:0]             in_meta,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [NUM_LANES*XLEN-1:0]     out_data,
    output logic [OP_BITS-1:0]            out_op,
    output logic [META_W-1:0]             out_meta,
    output logic [PID_W-1:0]              out_pid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          busy
);

    generate
        if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_cfg
            $error("NUM_THREADS must be a multiple of NUM_LANES");
        end
    endgenerate

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [NUM_THREADS-1:0]        r_tmask;
    logic [NUM_THREADS*XLEN-1:0]   r_data;
    logic [OP_BITS-1:0]            r_op;
    logic [META_W-1:0]             r_meta;
    logic [PID_W-1:0]              r_pid;
    logic                          r_sop;

    logic [NUM_PACKETS-1:0]        w_slice_nz;
    logic [NUM_PACKETS-1:0]        w_in_slice_nz;
    logic [NUM_LANES-1:0]          w_pkt_tmask [NUM_PACKETS];
    logic [NUM_LANES*XLEN-1:0]     w_pkt_data  [NUM_PACKETS];
    logic [PID_W-1:0]              w_next_pid;
    logic                          w_has_next;
    logic [PID_W-1:0]              w_first_pid;
    logic                          w_fire;
    logic                          w_accept;
    logic                          w_eop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PACKETS; gi++) begin : g_slice
            assign w_slice_nz[gi]    = |r_tmask[gi*NUM_LANES +: NUM_LANES];
            assign w_in_slice_nz[gi] = |in_tmask[gi*NUM_LANES +: NUM_LANES];
            assign w_pkt_tmask[gi]   = r_tmask[gi*NUM_LANES +: NUM_LANES];
            assign w_pkt_data[gi]    = r_data[gi*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        end
    endgenerate

    // Lowest active group above the current one; none left means this is eop.
    always_comb begin
        w_next_pid = '0;
        w_has_next = 1'b0;
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (w_slice_nz[p] && (p > int'(r_pid))) begin
                w_has_next = 1'b1;
                w_next_pid = PID_W'(p);
            end
        end
    end

    // An all-zero mask still yields one packet at pid 0.
    always_comb begin
        w_first_pid = '0;
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (w_in_slice_nz[p]) begin
                w_first_pid = PID_W'(p);
            end
        end
    end

    assign w_eop    = ~w_has_next;
    assign w_fire   = out_valid & out_ready;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = S_SEND;
            S_SEND: if (w_fire && w_eop) w_state_next = in_valid ? S_SEND : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: in_ready = reset;
            S_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = reset & out_ready & w_eop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmask <= '0;
            r_data  <= '0;
            r_op    <= '0;
            r_meta  <= '0;
            r_pid   <= '0;
            r_sop   <= 1'b0;
        end else if (w_accept) begin
            r_tmask <= in_tmask;
            r_data  <= in_data;
            r_op    <= in_op;
            r_meta  <= in_meta;
            r_pid   <= w_first_pid;
            r_sop   <= 1'b1;
        end else if (w_fire) begin
            r_pid   <= w_next_pid;
            r_sop   <= 1'b0;
        end
    end

    assign out_tmask = w_pkt_tmask[r_pid];
    assign out_data  = w_pkt_data[r_pid];
    assign out_op    = r_op;
    assign out_meta  = r_meta;
    assign out_pid   = r_pid;
    assign out_sop   = r_sop;
    assign out_eop   = w_eop;

endmodule

// File: tb/tb_vx_reduce_packetizer.sv
// Bench for vx_reduce_packetizer: directed scenarios plus random traffic,
// checked against a queue of expected packets built from each accepted request.
module tb_vx_reduce_packetizer;

    localparam int NT = 8;
    localparam int NL = 2;
    localparam int XL = 32;
    localparam int OB = 4;
    localparam int MW = 64;
    localparam int NP = NT / NL;

    typedef struct packed {
        logic [1:0]     pid;
        logic [NL-1:0]  mask;
        logic [63:0]    data;
        logic [OB-1:0]  op;
        logic [MW-1:0]  meta;
        logic           sop;
        logic           eop;
    } pkt_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NT-1:0]     in_tmask;
    logic [NT*XL-1:0]  in_data;
    logic [OB-1:0]     in_op;
    logic [MW-1:0]     in_meta;
    logic              out_valid;
    logic              out_ready;
    logic [NL-1:0]     out_tmask;
    logic [NL*XL-1:0]  out_data;
    logic [OB-1:0]     out_op;
    logic [MW-1:0]     out_meta;
    logic [1:0]        out_pid;
    logic              out_sop;
    logic              out_eop;
    logic              busy;

    int   n_checks = 0;
    int   n_errors = 0;
    pkt_t exp_q[$];
    bit   rst_prev;

    vx_reduce_packetizer #(
        .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .OP_BITS(OB), .META_W(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
        .in_data(in_data), .in_op(in_op), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask),
        .out_data(out_data), .out_op(out_op), .out_meta(out_meta),
        .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected packets: every nonzero lane group in ascending order, or one empty pid-0 packet.
    task automatic push_req(input logic [NT-1:0] m, input logic [NT*XL-1:0] d,
                            input logic [OB-1:0] op, input logic [MW-1:0] meta);
        pkt_t pk;
        bit   first = 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (m[p*NL +: NL] != 0) begin
                pk.pid  = 2'(p);
                pk.mask = m[p*NL +: NL];
                pk.data = d[p*64 +: 64];
                pk.op   = op;
                pk.meta = meta;
                pk.sop  = first;
                pk.eop  = 1'b0;
                first   = 1'b0;
                exp_q.push_back(pk);
            end
        end
        if (first) begin
            pk.pid  = 2'd0;
            pk.mask = '0;
            pk.data = d[63:0];
            pk.op   = op;
            pk.meta = meta;
            pk.sop  = 1'b1;
            pk.eop  = 1'b0;
            exp_q.push_back(pk);
        end
        pk = exp_q[exp_q.size()-1];
        pk.eop = 1'b1;
        exp_q[exp_q.size()-1] = pk;
        $display("req tmask=%02h op=%0h packets=%0d", m, op, exp_q.size());
    endtask

    // One clock: drive at posedge+1, check and update the model at the negedge.
    task automatic tick(input bit rst, input bit iv, input logic [NT-1:0] m, input bit ordy);
        logic [NT*XL-1:0] d;
        bit               exp_ready;
        pkt_t             e;
        for (int k = 0; k < NT; k++) d[k*XL +: XL] = $urandom;
        reset     = rst ? 1'b0 : 1'b1;
        in_valid  = iv;
        in_tmask  = m;
        in_data   = d;
        in_op     = OB'($urandom);
        in_meta   = {$urandom, $urandom};
        out_ready = ordy;
        @(negedge clk);
        if (rst) begin
            check_val("rst_in_ready", in_ready, 0);
            if (rst_prev) begin
                check_val("rst_out_valid", out_valid, 0);
                check_val("rst_busy", busy, 0);
            end
            exp_q.delete();
        end else begin
            exp_ready = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
            check_val("out_valid", out_valid, exp_q.size() != 0);
            check_val("busy", busy, exp_q.size() != 0);
            check_val("in_ready", in_ready, exp_ready);
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check_val("pid", out_pid, e.pid);
                check_val("tmask", out_tmask, e.mask);
                check_val("data", out_data, e.data);
                check_val("op", out_op, e.op);
                check_val("meta", out_meta, e.meta);
                check_val("sop", out_sop, e.sop);
                check_val("eop", out_eop, e.eop);
                if (ordy) begin
                    $display("pkt pid=%0d tmask=%b sop=%0d eop=%0d", out_pid, out_tmask, out_sop, out_eop);
                    void'(exp_q.pop_front());
                end
            end
            if (iv && exp_ready) push_req(m, d, in_op, in_meta);
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick(0, 0, '0, 1);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(0, 0, '0, 1);
    endtask

    initial begin
        logic [NT-1:0] m;
        bit rst, iv, ordy;
        reset = 1'b0; in_valid = 1'b0; in_tmask = '0; in_data = '0;
        in_op = '0; in_meta = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_prev = 1'b1;
        tick(1, 0, '0, 0);
        tick(1, 0, '0, 0);
        tick(0, 0, '0, 1);

        tick(0, 1, 8'hFF, 1); drain();
        tick(0, 1, 8'h81, 1); drain();
        tick(0, 1, 8'h30, 1); drain();
        tick(0, 1, 8'h00, 1); drain();

        // Stall three cycles on pid 1.
        tick(0, 1, 8'hFF, 1);
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);
        tick(0, 0, '0, 0);
        drain();

        // Back-to-back requests; second accepted on the eop cycle.
        tick(0, 1, 8'h0F, 1);
        tick(0, 1, 8'hC0, 1);
        tick(0, 1, 8'hC0, 1);
        drain();

        // Reset in the middle of a request.
        tick(0, 1, 8'hFF, 1);
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        tick(1, 0, '0, 1);
        tick(1, 0, '0, 1);
        tick(0, 1, 8'h03, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = NT'(1 << $urandom_range(0, NT-1));
                default: m = NT'($urandom);
            endcase
            rst  = ($urandom_range(0, 49) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 7);
            tick(rst, iv, m, ordy);
        end
        tick(0, 0, '0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
